// File: rtl/evt_watchdog_pkg.sv
// Shared types and constants for the multi-channel event watchdog.
package evt_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } wd_state_t;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        TMO  = 2'd1,
        MIS  = 2'd2
    } wd_result_t;

    localparam logic [7:0] ACK_POS = 8'hA5;
    localparam logic [7:0] ACK_NEG = 8'h5A;

endpackage

// File: rtl/evt_watchdog_if.sv
// Arm/event inputs and status outputs of the watchdog, grouped as one bundle.
interface evt_watchdog_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        arm;
    logic [NUM_CH-1:0]        chk_en;
    logic [NUM_CH*DATA_W-1:0] exp_data;
    logic [NUM_CH-1:0]        evt;
    logic [NUM_CH*DATA_W-1:0] evt_data;
    logic                     clr;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        pass;
    logic [NUM_CH-1:0]        fail;
    logic [NUM_CH-1:0]        tmo_err;
    logic [NUM_CH-1:0]        mis_err;
    logic [7:0]               err_cnt;

    modport master (
        output arm, chk_en, exp_data, evt, evt_data, clr,
        input  busy, pass, fail, tmo_err, mis_err, err_cnt
    );

    modport slave (
        input  arm, chk_en, exp_data, evt, evt_data, clr,
        output busy, pass, fail, tmo_err, mis_err, err_cnt
    );
endinterface

// File: rtl/evt_watch_ch.sv
// One watchdog channel: arm capture, cycle budget counter, rising-edge detect
// and a registered one-cycle pass/fail result.
module evt_watch_ch
    import evt_watchdog_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'd1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              evt,
    input  logic [DATA_W-1:0] evt_data,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output wd_result_t        result
);
    localparam logic [CNT_W-1:0] TERM = TIMEOUT - CNT_W'(1);

    wd_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic              chk_q;
    logic              evt_q;
    logic [DATA_W-1:0] exp_q;
    logic              rise;
    logic              mismatch;

    assign rise     = evt & ~evt_q;
    assign mismatch = chk_q && (evt_data != exp_q);

    // Payload reference is pure data; it is only meaningful while chk_q is set.
    always_ff @(posedge clk) begin
        if (arm) exp_q <= exp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            chk_q  <= 1'b0;
            evt_q  <= 1'b0;
            busy   <= 1'b0;
            pass   <= 1'b0;
            fail   <= 1'b0;
            result <= PASS;
        end else begin
            evt_q <= evt;
            pass  <= 1'b0;
            fail  <= 1'b0;
            if (arm) chk_q <= chk_en;
            case (state)
                WAIT: begin
                    if (arm) begin
                        cnt <= '0;
                    end else if (rise) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        pass   <= ~mismatch;
                        fail   <= mismatch;
                        result <= mismatch ? MIS : PASS;
                    end else if (cnt == TERM) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        fail   <= 1'b1;
                        result <= TMO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new arm; DONE otherwise lasts one cycle.
                    if (arm) begin
                        cnt   <= '0;
                        state <= WAIT;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/evt_watchdog.sv
// Multi-channel event watchdog top: per-channel watchers plus sticky error
// flags and a saturating failure counter.
module evt_watchdog
    import evt_watchdog_pkg::*;
#(
    parameter int               NUM_CH  = 4,
    parameter int               DATA_W  = 8,
    parameter int               CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'd1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    evt_watchdog_if.slave bus
);
    logic [NUM_CH-1:0] busy_v;
    logic [NUM_CH-1:0] pass_v;
    logic [NUM_CH-1:0] fail_v;
    logic [NUM_CH-1:0] tmo_v;
    logic [NUM_CH-1:0] mis_v;
    wd_result_t        res_v [NUM_CH];
    logic [NUM_CH-1:0] tmo_err_q;
    logic [NUM_CH-1:0] mis_err_q;
    logic [7:0]        err_cnt_q;
    logic [7:0]        fail_cnt;

    function automatic logic [7:0] popcount(input logic [NUM_CH-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) n = n + 8'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        evt_watch_ch #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .arm      (bus.arm[i]),
            .chk_en   (bus.chk_en[i]),
            .exp_data (bus.exp_data[i*DATA_W +: DATA_W]),
            .evt      (bus.evt[i]),
            .evt_data (bus.evt_data[i*DATA_W +: DATA_W]),
            .busy     (busy_v[i]),
            .pass     (pass_v[i]),
            .fail     (fail_v[i]),
            .result   (res_v[i])
        );
        assign tmo_v[i] = fail_v[i] && (res_v[i] == TMO);
        assign mis_v[i] = fail_v[i] && (res_v[i] == MIS);
    end

    assign fail_cnt = popcount(fail_v);

    // A flag set or new failures in the same cycle as clr survive the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_err_q <= '0;
            mis_err_q <= '0;
            err_cnt_q <= '0;
        end else if (bus.clr) begin
            tmo_err_q <= tmo_v;
            mis_err_q <= mis_v;
            err_cnt_q <= fail_cnt;
        end else begin
            tmo_err_q <= tmo_err_q | tmo_v;
            mis_err_q <= mis_err_q | mis_v;
            err_cnt_q <= sat_add(err_cnt_q, fail_cnt);
        end
    end

    assign bus.busy    = busy_v;
    assign bus.pass    = pass_v;
    assign bus.fail    = fail_v;
    assign bus.tmo_err = tmo_err_q;
    assign bus.mis_err = mis_err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_evt_watchdog.sv
// Self-checking bench for evt_watchdog: directed scenarios plus random traffic,
// all compared every cycle against a cycle-numbered behavioural model.
module tb_evt_watchdog;
    localparam int NCH      = 4;
    localparam int DW       = 8;
    localparam int CW       = 24;
    localparam int T_BUDGET = 16;
    localparam logic [7:0] ACK_P = evt_watchdog_pkg::ACK_POS;
    localparam logic [7:0] ACK_N = evt_watchdog_pkg::ACK_NEG;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    evt_watchdog_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

    evt_watchdog #(
        .NUM_CH  (NCH),
        .DATA_W  (DW),
        .CNT_W   (CW),
        .TIMEOUT (24'd16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_arm = 0;
    int lat;

    // Model: a channel waits from the posedge after arm; deadline by absolute cycle number.
    bit             m_wait  [NCH];
    int             m_start [NCH];
    bit             m_chk   [NCH];
    logic [DW-1:0]  m_exp   [NCH];
    logic [NCH-1:0] m_pass, m_fail, m_tmo, m_mis, m_tmo_err, m_mis_err, evt_prev;
    int             m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_wait[c]  = 1'b0;
            m_start[c] = 0;
            m_chk[c]   = 1'b0;
            m_exp[c]   = '0;
        end
        m_pass = '0; m_fail = '0; m_tmo = '0; m_mis = '0;
        m_tmo_err = '0; m_mis_err = '0; evt_prev = '0;
        m_err = 0;
    endtask

    task automatic model_edge();
        int pc;
        pc = $countones(m_fail);
        if (bus.clr) begin
            m_tmo_err = m_tmo;
            m_mis_err = m_mis;
            m_err     = pc;
        end else begin
            m_tmo_err = m_tmo_err | m_tmo;
            m_mis_err = m_mis_err | m_mis;
            m_err     = (m_err + pc > 255) ? 255 : m_err + pc;
        end
        m_pass = '0; m_fail = '0; m_tmo = '0; m_mis = '0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.arm[c]) begin
                m_wait[c]  = 1'b1;
                m_start[c] = cyc + 1;
                m_chk[c]   = bus.chk_en[c];
                m_exp[c]   = bus.exp_data[c*DW +: DW];
            end else if (m_wait[c]) begin
                if (bus.evt[c] && !evt_prev[c]) begin
                    m_wait[c] = 1'b0;
                    if (m_chk[c] && bus.evt_data[c*DW +: DW] != m_exp[c]) begin
                        m_fail[c] = 1'b1;
                        m_mis[c]  = 1'b1;
                    end else begin
                        m_pass[c] = 1'b1;
                    end
                end else if (cyc - m_start[c] == T_BUDGET - 1) begin
                    m_wait[c] = 1'b0;
                    m_fail[c] = 1'b1;
                    m_tmo[c]  = 1'b1;
                end
            end
        end
        evt_prev = bus.evt;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] b;
        for (int c = 0; c < NCH; c++) b[c] = m_wait[c];
        check_eq("busy",    32'(bus.busy),    32'(b));
        check_eq("pass",    32'(bus.pass),    32'(m_pass));
        check_eq("fail",    32'(bus.fail),    32'(m_fail));
        check_eq("tmo_err", 32'(bus.tmo_err), 32'(m_tmo_err));
        check_eq("mis_err", 32'(bus.mis_err), 32'(m_mis_err));
        check_eq("err_cnt", 32'(bus.err_cnt), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic arm_mask(input logic [NCH-1:0] m, input bit chk, input logic [7:0] exp);
        bus.arm    = m;
        bus.chk_en = chk ? m : '0;
        for (int c = 0; c < NCH; c++) bus.exp_data[c*DW +: DW] = exp;
        step();
        last_arm = cyc;
        bus.arm  = '0;
    endtask

    // Latency is in the arm-relative numbering where arm sampled at N shows busy at N+1.
    task automatic wait_pulse(input int ch, input bit want_fail, input int budget, output int l);
        l = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((want_fail ? bus.fail[ch] : bus.pass[ch]) === 1'b1) begin
                l = cyc - last_arm + 1;
                break;
            end
        end
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_busy",    32'(bus.busy),    32'd0);
        check_eq("rst_pass",    32'(bus.pass),    32'd0);
        check_eq("rst_fail",    32'(bus.fail),    32'd0);
        check_eq("rst_tmo_err", 32'(bus.tmo_err), 32'd0);
        check_eq("rst_mis_err", 32'(bus.mis_err), 32'd0);
        check_eq("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        bus.arm = '0; bus.evt = '0; bus.clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.arm = '0; bus.chk_en = '0; bus.exp_data = '0;
        bus.evt = '0; bus.evt_data = '0; bus.clr = 1'b0;
        model_reset();
        #12;
        check_eq("init_busy",    32'(bus.busy),    32'd0);
        check_eq("init_err_cnt", 32'(bus.err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pass on WAIT cycle 5
        arm_mask(4'b0001, 1'b0, 8'h00);
        idle(5);
        bus.evt[0] = 1'b1;
        wait_pulse(0, 1'b0, 20, lat);
        check_eq("pass_lat", 32'(lat), 32'd7);
        check_eq("pass_err_cnt", 32'(bus.err_cnt), 32'd0);
        bus.evt[0] = 1'b0;
        idle(2);

        // Timeout, then an edge on the last legal WAIT cycle
        arm_mask(4'b0010, 1'b0, 8'h00);
        wait_pulse(1, 1'b1, 30, lat);
        check_eq("tmo_lat", 32'(lat), 32'd17);
        idle(1);
        check_eq("tmo_flag", 32'(bus.tmo_err[1]), 32'd1);
        check_eq("tmo_err_cnt", 32'(bus.err_cnt), 32'd1);
        arm_mask(4'b0010, 1'b0, 8'h00);
        idle(15);
        bus.evt[1] = 1'b1;
        wait_pulse(1, 1'b0, 20, lat);
        check_eq("last_edge_lat", 32'(lat), 32'd17);
        bus.evt[1] = 1'b0;
        idle(2);

        // Payload compare on ch2
        for (int c = 0; c < NCH; c++) bus.evt_data[c*DW +: DW] = ACK_P;
        arm_mask(4'b0100, 1'b1, ACK_P);
        idle(2);
        bus.evt[2] = 1'b1;
        wait_pulse(2, 1'b0, 20, lat);
        check_eq("ack_pos_lat", 32'(lat), 32'd4);
        bus.evt[2] = 1'b0;
        idle(1);
        bus.evt_data[2*DW +: DW] = ACK_N;
        arm_mask(4'b0100, 1'b1, ACK_P);
        idle(2);
        bus.evt[2] = 1'b1;
        wait_pulse(2, 1'b1, 20, lat);
        check_eq("ack_neg_lat", 32'(lat), 32'd4);
        idle(1);
        check_eq("mis_flag", 32'(bus.mis_err[2]), 32'd1);
        bus.evt[2] = 1'b0;
        idle(2);

        // Event already high across arm
        bus.evt[3] = 1'b1;
        idle(1);
        arm_mask(4'b1000, 1'b0, 8'h00);
        wait_pulse(3, 1'b1, 30, lat);
        check_eq("hi_evt_tmo_lat", 32'(lat), 32'd17);
        arm_mask(4'b1000, 1'b0, 8'h00);
        idle(1);
        bus.evt[3] = 1'b0;
        idle(1);
        bus.evt[3] = 1'b1;
        wait_pulse(3, 1'b0, 20, lat);
        check_eq("hi_evt_repass_lat", 32'(lat), 32'd4);
        bus.evt[3] = 1'b0;
        idle(2);

        // Re-arm at WAIT cycle 10 moves the deadline
        arm_mask(4'b0001, 1'b0, 8'h00);
        idle(10);
        arm_mask(4'b0001, 1'b0, 8'h00);
        wait_pulse(0, 1'b1, 30, lat);
        check_eq("rearm_tmo_lat", 32'(lat), 32'd17);

        // Arm coincident with an edge: stays waiting, edge is consumed
        arm_mask(4'b0001, 1'b0, 8'h00);
        idle(3);
        bus.evt[0] = 1'b1;
        arm_mask(4'b0001, 1'b0, 8'h00);
        wait_pulse(0, 1'b1, 30, lat);
        check_eq("arm_edge_tmo_lat", 32'(lat), 32'd17);
        bus.evt[0] = 1'b0;
        idle(2);

        // Four simultaneous timeouts after a clear
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        arm_mask(4'b1111, 1'b0, 8'h00);
        wait_pulse(0, 1'b1, 30, lat);
        idle(1);
        check_eq("four_tmo_err_cnt", 32'(bus.err_cnt), 32'd4);
        check_eq("four_tmo_flags",   32'(bus.tmo_err), 32'hF);

        // Saturation: 65 more rounds of four fails
        for (int r = 0; r < 65; r++) begin
            arm_mask(4'b1111, 1'b0, 8'h00);
            wait_pulse(0, 1'b1, 30, lat);
        end
        idle(1);
        check_eq("err_sat", 32'(bus.err_cnt), 32'd255);

        // Clear concurrent with a single fail
        arm_mask(4'b0010, 1'b0, 8'h00);
        wait_pulse(1, 1'b1, 30, lat);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check_eq("clr_fail_err_cnt", 32'(bus.err_cnt), 32'd1);
        check_eq("clr_fail_flags",   32'(bus.tmo_err), 32'h2);

        // Asynchronous reset while waiting
        arm_mask(4'b0101, 1'b0, 8'h00);
        idle(3);
        async_reset_check();
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.arm    = ($urandom_range(0, 5) == 0) ? NCH'($urandom()) : '0;
            bus.chk_en = NCH'($urandom());
            bus.clr    = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 4) == 0) bus.evt[c] = ~bus.evt[c];
                case ($urandom_range(0, 2))
                    0:       bus.evt_data[c*DW +: DW] = ACK_P;
                    1:       bus.evt_data[c*DW +: DW] = ACK_N;
                    default: bus.evt_data[c*DW +: DW] = 8'($urandom());
                endcase
                bus.exp_data[c*DW +: DW] = ($urandom_range(0, 3) == 0) ? ACK_N : ACK_P;
            end
            step();
        end
        bus.arm = '0; bus.clr = 1'b0;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/evt_watchdog.md
# evt_watchdog

Synthesizable multi-channel event watchdog for on-chip self-test of the Knight's Tour datapath. Each channel is armed by a pulse and must see a rising edge on its event input within a programmable cycle budget. An edge in time passes, an edge with mismatching payload fails, and no edge fails as a timeout. It turns the bench-only "wait for NEMO_setup / cal_done / ack with timeout" checks into hardware, generalised to `NUM_CH` channels with an optional data-compare mode.

## Interface
- `NUM_CH`, 4: number of independent channels.
- `DATA_W`, 8: payload width per channel; the positive ack is `8'hA5`.
- `CNT_W`, 24: timeout counter width.
- `TIMEOUT`, 24'd1_000_000: cycle budget per arm. Legal range is 1 to 2^CNT_W−1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  NUM_CH  per-channel arm pulse.
- `chk_en`  in  NUM_CH  sampled with `arm`; enables payload compare.
- `exp_data`  in  NUM_CH*DATA_W  expected payload, sampled with `arm`.
- `evt`  in  NUM_CH  event level, for example `cal_done` or `resp_rdy`.
- `evt_data`  in  NUM_CH*DATA_W  payload sampled on the event edge, for example `resp`.
- `busy`  out  NUM_CH  channel armed and waiting.
- `pass`  out  NUM_CH  1-cycle pulse on success.
- `fail`  out  NUM_CH  1-cycle pulse on timeout or mismatch.
- `tmo_err`  out  NUM_CH  sticky timeout flag.
- `mis_err`  out  NUM_CH  sticky mismatch flag.
- `err_cnt`  out  8  saturating total failure count.
- `clr`  in  1  synchronous clear of the sticky flags and `err_cnt`.

## Operation
- Per-channel FSM with states IDLE, WAIT and DONE. DONE lasts exactly one cycle, drives `pass` or `fail`, then returns to IDLE.
- **IDLE, arm sampled:**
  - capture `chk_en` and `exp_data`
  - `cnt`←0
  - go to WAIT
- **WAIT, rising edge detected (`evt & ~evt_q`):**
  - if `chk_en` is captured and `evt_data != exp_data`, result is mismatch
  - otherwise result is pass
  - go to DONE
- **WAIT, no edge and `cnt == TIMEOUT-1`:** result is timeout; go to DONE.
- **WAIT, otherwise:** `cnt`++.
- **Re-arm in WAIT:** `cnt`←0, the capture registers are reloaded, and the channel stays in WAIT. Re-arm has priority over an edge or timeout in the same cycle.
- **Arm in DONE:** accepted. The channel goes to WAIT and the result pulse is still emitted.
- **Edge and terminal count in the same cycle:** the edge wins.
- **Edge detection:** `evt_q` is updated every cycle in every state. An `evt` already high when armed does not pass; only a fresh 0→1 transition counts.
- **Sticky flags:** `tmo_err`/`mis_err` are set on the corresponding fail and cleared only by `clr` or reset. If a set and `clr` occur in the same cycle, the set wins.
- **err_cnt:**
  - adds popcount(`fail`) each cycle
  - saturates at 255
  - if `clr` and new fails occur together, loads popcount(`fail`)
- **Reset values:** all outputs are 0 and all FSMs are in IDLE. `evt_q` resets to 0, so an `evt` high out of reset is treated as an edge, but only if the channel is already in WAIT, which cannot happen on the first cycle.

## Timing
- `arm` is sampled at posedge N; `busy` is high from N+1.
- An edge in WAIT cycle k (k = 0 to TIMEOUT−1, counted from N+1) gives `pass`/`fail` at N+k+2, and `busy` falls in the same cycle.
- With no edge, a timeout `fail` asserts exactly TIMEOUT+1 cycles after `arm` was sampled.
- Sticky flags and `err_cnt` update the cycle after the `fail` pulse.
- `pass`/`fail` are registered FSM outputs with no combinational path from inputs.

## Structure
- **`evt_watchdog_pkg`:**
  - `wd_state_t` (IDLE, WAIT, DONE)
  - `wd_result_t` (PASS, TMO, MIS)
  - `ACK_POS = 8'hA5`
  - `ACK_NEG = 8'h5A`
- **Sub-module `evt_watch_ch`:** one channel (FSM, counter, edge detect, capture), instantiated `NUM_CH` times by generate.
- **Top level:** holds only the sticky flags, the popcount and the saturating `err_cnt`.

## Test plan
Directed scenarios, with TIMEOUT=16 unless noted:
- **Pass:** arm ch0 (`chk_en`=0), `evt` rises at WAIT cycle 5 → `pass[0]` at arm+7, `busy[0]` low at the same cycle, `err_cnt`=0.
- **Timeout:** arm ch1 and never raise `evt` → `fail[1]` at arm+17, `tmo_err[1]`=1, `err_cnt`=1. An edge at WAIT cycle 15 (the last legal one) passes instead.
- **Ack compare:** arm ch2 with `chk_en`=1, `exp_data`=A5:
  - `evt_data`=A5 on the edge → pass
  - re-run with `evt_data`=5A → `fail[2]`, `mis_err[2]`=1
- **Already-high event:** `evt` held high across arm → timeout. Dropping and re-raising `evt` → pass.
- **Re-arm and collisions:**
  - re-arm at WAIT cycle 10 → timeout moves to re-arm+17
  - edge coincident with the terminal count → pass
  - arm coincident with an edge → stays WAIT, no pulse
- **Error accounting and reset:**
  - four channels time out in the same cycle → `err_cnt` +4
  - drive 260 fails → 255
  - `clr` with a concurrent fail → `err_cnt`=1
  - `rst_n` low mid-WAIT → all outputs 0 asynchronously, FSM in IDLE
